// File: rtl/div_pkg.sv
// Shared types and helpers for the seq_div_unit iterative divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Counter width: must hold the value parallelism, not only parallelism-1.
    function automatic int cnt_w(input int parallelism);
        return $clog2(parallelism + 1);
    endfunction

endpackage

// File: rtl/div_cond_neg.sv
// Combinational conditional two's complement: y = en ? -a : a.
module div_cond_neg #(
    parameter int unsigned width = 32
) (
    input  logic             en,
    input  logic [width-1:0] a,
    output logic [width-1:0] y
);

    always_comb begin
        y = a;
        if (en) begin
            y = (~a) + width'(1);
        end
    end

endmodule

// File: rtl/seq_div_unit.sv
// Iterative radix-2 restoring divider with handshake, abort and RISC-V special cases.
// Optional macro DIV_SPECIAL_FAST_EN: divide-by-zero / signed overflow bypass CALC.
module seq_div_unit
    import div_pkg::*;
#(
    parameter int unsigned parallelism = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid,
    input  logic                   usigned_n,
    input  logic                   abort,
    input  logic [parallelism-1:0] dividend,
    input  logic [parallelism-1:0] divisor,
    output logic                   in_ready,
    output logic [parallelism-1:0] quotient,
    output logic [parallelism-1:0] reminder,
    output logic                   res_ready,
    output logic                   div_by_zero,
    output logic                   overflow
);

    localparam int unsigned P  = parallelism;
    localparam int unsigned CW = cnt_w(parallelism);
    localparam logic [P-1:0] MIN_VAL = {1'b1, {(P-1){1'b0}}};

    div_state_t state, state_nx;

    logic [CW-1:0] cnt;
    logic [P-1:0]  rem_r, dvd_r, dsr_r, orig_r;
    logic          q_neg, r_neg, dz_p, ov_p;

    logic          accept, is_dz, is_ov, special;
    logic [P-1:0]  mag_a, mag_b, q_fix, r_fix;
    logic [P:0]    diff;

    assign accept  = valid && (state == IDLE) && !abort;
    assign is_dz   = (divisor == '0);
    assign is_ov   = usigned_n && (dividend == MIN_VAL) && (divisor == '1);
    assign special = is_dz || is_ov;
    assign diff    = {rem_r, dvd_r[P-1]} - {1'b0, dsr_r};

    div_cond_neg #(.width(P)) u_neg_a (.en(usigned_n & dividend[P-1]), .a(dividend), .y(mag_a));
    div_cond_neg #(.width(P)) u_neg_b (.en(usigned_n & divisor[P-1]),  .a(divisor),  .y(mag_b));
    div_cond_neg #(.width(P)) u_neg_q (.en(q_neg), .a(dvd_r), .y(q_fix));
    div_cond_neg #(.width(P)) u_neg_r (.en(r_neg), .a(rem_r), .y(r_fix));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef DIV_SPECIAL_FAST_EN
                    state_nx = special ? FIX : CALC;
`else
                    state_nx = CALC;
`endif
                end
            end
            CALC: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (cnt == CW'(P - 1)) begin
                    state_nx = FIX;
                end
            end
            FIX:     state_nx = abort ? IDLE : DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        res_ready = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    res_ready = 1'b1;
            default: ;
        endcase
    end

    // Quotient bits shift into dvd_r as dividend bits shift out of it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            rem_r       <= '0;
            dvd_r       <= '0;
            dsr_r       <= '0;
            orig_r      <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dz_p        <= 1'b0;
            ov_p        <= 1'b0;
            quotient    <= '0;
            reminder    <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt         <= '0;
                        rem_r       <= '0;
                        dvd_r       <= mag_a;
                        dsr_r       <= mag_b;
                        orig_r      <= dividend;
                        q_neg       <= usigned_n & (dividend[P-1] ^ divisor[P-1]);
                        r_neg       <= usigned_n & dividend[P-1];
                        dz_p        <= is_dz;
                        ov_p        <= is_ov;
                        quotient    <= '0;
                        reminder    <= '0;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                CALC: begin
                    cnt   <= cnt + CW'(1);
                    dvd_r <= {dvd_r[P-2:0], ~diff[P]};
                    if (!diff[P]) begin
                        rem_r <= diff[P-1:0];
                    end else begin
                        rem_r <= {rem_r[P-2:0], dvd_r[P-1]};
                    end
                end
                FIX: begin
                    if (!abort) begin
                        div_by_zero <= dz_p;
                        overflow    <= ov_p;
                        if (dz_p) begin
                            quotient <= '1;
                            reminder <= orig_r;
                        end else if (ov_p) begin
                            quotient <= MIN_VAL;
                            reminder <= '0;
                        end else begin
                            quotient <= q_fix;
                            reminder <= r_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_unit.sv
// Self-checking bench for seq_div_unit at widths 32 and 8 (honours DIV_SPECIAL_FAST_EN).
module tb_seq_div_unit;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
        int          lat;
    } vec_t;

`ifdef DIV_SPECIAL_FAST_EN
    localparam int SP_LAT = 2;
`else
    localparam int SP_LAT = 34;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, usigned_n, abort;
    logic [31:0] dividend, divisor, quotient, reminder;
    logic        in_ready, res_ready, div_by_zero, overflow;

    logic        valid8, usigned8, abort8;
    logic [7:0]  dvd8, dsr8, quo8, rem8;
    logic        in_ready8, res_ready8, dz8, ov8;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_div_unit #(.parallelism(32)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .usigned_n(usigned_n), .abort(abort),
        .dividend(dividend), .divisor(divisor), .in_ready(in_ready), .quotient(quotient),
        .reminder(reminder), .res_ready(res_ready), .div_by_zero(div_by_zero), .overflow(overflow)
    );

    seq_div_unit #(.parallelism(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .valid(valid8), .usigned_n(usigned8), .abort(abort8),
        .dividend(dvd8), .divisor(dsr8), .in_ready(in_ready8), .quotient(quo8),
        .reminder(rem8), .res_ready(res_ready8), .div_by_zero(dz8), .overflow(ov8)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Latency = rising edges from the accept edge to the edge that samples res_ready high.
    task automatic wait_res32(output int lat);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (res_ready) begin
                lat = k + 1;
                break;
            end
        end
    endtask

    task automatic wait_res8(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (res_ready8) begin
                lat = k + 1;
                break;
            end
        end
    endtask

    task automatic accept32(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        usigned_n = sgn;
        dividend  = a;
        divisor   = b;
        valid     = 1'b1;
        step();
        valid     = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        check({v.name, " in_ready_before"}, 32'(in_ready), 32'd1);
        accept32(v.sgn, v.a, v.b);
        wait_res32(lat);
        check({v.name, " latency"}, 32'(lat), 32'(v.lat));
        check({v.name, " quotient"}, quotient, v.q);
        check({v.name, " reminder"}, reminder, v.r);
        check({v.name, " div_by_zero"}, 32'(div_by_zero), 32'(v.dz));
        check({v.name, " overflow"}, 32'(overflow), 32'(v.ov));
        step();
        check({v.name, " res_ready_pulse"}, 32'(res_ready), 32'd0);
        check({v.name, " in_ready_after"}, 32'(in_ready), 32'd1);
        check({v.name, " quotient_held"}, quotient, v.q);
    endtask

    initial begin
        vec_t vt[10];
        int   lat, seen;

        vt[0] = '{"u_75_div_a",  1'b0, 32'h75,       32'hA,        32'hB,        32'h7,        1'b0, 1'b0, 34};
        vt[1] = '{"s_m7_div_2",  1'b1, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 34};
        vt[2] = '{"s_div_zero",  1'b1, 32'h80000005, 32'h0,        32'hFFFFFFFF, 32'h80000005, 1'b1, 1'b0, SP_LAT};
        vt[3] = '{"s_overflow",  1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        1'b0, 1'b1, SP_LAT};
        vt[4] = '{"u_min_by_m1", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0, 1'b0, 34};
        vt[5] = '{"u_div_zero",  1'b0, 32'd100,      32'h0,        32'hFFFFFFFF, 32'd100,      1'b1, 1'b0, SP_LAT};
        vt[6] = '{"s_7_div_m2",  1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 1'b0, 34};
        vt[7] = '{"s_m7_div_m2", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0, 1'b0, 34};
        vt[8] = '{"u_max_div_1", 1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 34};
        vt[9] = '{"u_5_div_9",   1'b0, 32'd5,        32'd9,        32'd0,        32'd5,        1'b0, 1'b0, 34};

        rst_n = 1'b0; abort = 1'b0; abort8 = 1'b0;
        valid = 1'b1; usigned_n = 1'b0; dividend = 32'd9; divisor = 32'd3;
        valid8 = 1'b0; usigned8 = 1'b0; dvd8 = '0; dsr8 = '0;
        step(); step(); step();
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst res_ready", 32'(res_ready), 32'd0);
        check("rst quotient", quotient, 32'd0);
        check("rst reminder", reminder, 32'd0);
        check("rst flags", {30'd0, div_by_zero, overflow}, 32'd0);
        valid = 1'b0;
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            run_vec(vt[i]);
        end

        // Abort ten cycles into CALC: no result, back to IDLE immediately.
        accept32(1'b0, 32'd100, 32'd7);
        repeat (9) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (res_ready) seen++;
            step();
        end
        check("abort no_res_ready", 32'(seen), 32'd0);
        check("abort quotient_kept", quotient, 32'd0);
        run_vec('{"after_abort", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 34});

        // Reset mid-CALC: everything back to zero, no result.
        accept32(1'b0, 32'd100, 32'd7);
        repeat (10) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst in_ready", 32'(in_ready), 32'd1);
        check("midrst quotient", quotient, 32'd0);
        check("midrst reminder", reminder, 32'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (res_ready) seen++;
            step();
        end
        check("midrst no_res_ready", 32'(seen), 32'd0);

        // Width 8, back-to-back with valid held high.
        valid8 = 1'b1; usigned8 = 1'b0; dvd8 = 8'd200; dsr8 = 8'd3;
        step();
        check("w8 first_accept", 32'(in_ready8), 32'd0);
        usigned8 = 1'b1; dvd8 = 8'h9C; dsr8 = 8'h05;
        wait_res8(lat);
        check("w8 lat1", 32'(lat), 32'd10);
        check("w8 quotient1", 32'(quo8), 32'd66);
        check("w8 reminder1", 32'(rem8), 32'd2);
        step();
        check("w8 idle_gap", 32'(in_ready8), 32'd1);
        check("w8 pulse1", 32'(res_ready8), 32'd0);
        step();
        check("w8 second_accept", 32'(in_ready8), 32'd0);
        valid8 = 1'b0;
        wait_res8(lat);
        check("w8 lat2", 32'(lat), 32'd10);
        check("w8 quotient2", 32'(quo8), 32'hEC);
        check("w8 reminder2", 32'(rem8), 32'd0);
        check("w8 flags2", {30'd0, dz8, ov8}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
